// File: rtl/ex_seg_if.sv
// Handshake and data bundle between the decode stage, the execute stage and the memory stage.
// The execute stage connects through the slave modport; the driving environment uses master.
interface ex_seg_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] NPCi;
    logic [31:0] IRi;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] NPCo;
    logic [31:0] IRo;
    logic [31:0] ALUOut;
    logic [31:0] Bo;
    logic        Cond;
    logic [31:0] Target;

    modport master (
        output in_valid, NPCi, IRi, A, B, Imm, out_ready,
        input  in_ready, out_valid, NPCo, IRo, ALUOut, Bo, Cond, Target
    );

    modport slave (
        input  in_valid, NPCi, IRi, A, B, Imm, out_ready,
        output in_ready, out_valid, NPCo, IRo, ALUOut, Bo, Cond, Target
    );
endinterface

// File: rtl/ex_seg.sv
// Execute pipeline stage: single-cycle ALU, branch/jump resolution and a 32-cycle
// shift-add multiplier, with valid/ready handshakes on both sides.
module ex_seg (
    input  logic     clk,
    input  logic     rst,
    ex_seg_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] b_q, b_d;
    logic        cond_q, cond_d;
    logic [31:0] target_q, target_d;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] alu_res;
    logic        cond_res;
    logic [31:0] target_res;
    logic        is_mul;
    logic        in_ready;
    logic        accept;
    logic [31:0] acc_next;

    assign op       = bus.IRi[31:26];
    assign funct    = bus.IRi[5:0];
    assign in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready) && !rst;
    assign accept   = in_ready && bus.in_valid;
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : 32'h0);

    // Instruction decode; unrecognised encodings fall through as NOPs.
    always_comb begin
        alu_res    = 32'h0;
        cond_res   = 1'b0;
        target_res = 32'h0;
        is_mul     = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100000: alu_res = bus.A + bus.B;
                    6'b100010: alu_res = bus.A - bus.B;
                    6'b100100: alu_res = bus.A & bus.B;
                    6'b100101: alu_res = bus.A | bus.B;
                    6'b101010: alu_res = {31'h0, $signed(bus.A) < $signed(bus.B)};
                    6'b011000: is_mul  = 1'b1;
                    default:   alu_res = 32'h0;
                endcase
            end
            6'b001000: alu_res = bus.A + bus.Imm;
            6'b001100: alu_res = bus.A & {16'h0, bus.IRi[15:0]};
            6'b100011,
            6'b101011: alu_res = bus.A + bus.Imm;
            6'b000100: begin
                cond_res   = (bus.A == bus.B);
                target_res = bus.NPCi + {bus.Imm[29:0], 2'b00};
            end
            6'b000010: begin
                cond_res   = 1'b1;
                target_res = {bus.NPCi[31:28], bus.IRi[25:0], 2'b00};
            end
            default: alu_res = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        npc_d       = npc_q;
        ir_d        = ir_q;
        alu_d       = alu_q;
        b_d         = b_q;
        cond_d      = cond_q;
        target_d    = target_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    npc_d = bus.NPCi;
                    ir_d  = bus.IRi;
                    b_d   = bus.B;
                    if (is_mul) begin
                        state_d     = StMul;
                        cnt_d       = 5'd0;
                        mcand_d     = bus.A;
                        mplier_d    = bus.B;
                        acc_d       = 32'h0;
                        cond_d      = 1'b0;
                        target_d    = 32'h0;
                        out_valid_d = 1'b0;
                    end else begin
                        alu_d       = alu_res;
                        cond_d      = cond_res;
                        target_d    = target_res;
                        out_valid_d = 1'b1;
                    end
                end else if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            StMul: begin
                acc_d    = acc_next;
                mcand_d  = {mcand_q[30:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q + 5'd1;
                // Last iteration: the product is complete on this edge.
                if (cnt_q == 5'd31) begin
                    alu_d       = acc_next;
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 5'd0;
            mcand_q     <= 32'h0;
            mplier_q    <= 32'h0;
            acc_q       <= 32'h0;
            out_valid_q <= 1'b0;
            npc_q       <= 32'h0;
            ir_q        <= 32'h0;
            alu_q       <= 32'h0;
            b_q         <= 32'h0;
            cond_q      <= 1'b0;
            target_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            npc_q       <= npc_d;
            ir_q        <= ir_d;
            alu_q       <= alu_d;
            b_q         <= b_d;
            cond_q      <= cond_d;
            target_q    <= target_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.NPCo      = npc_q;
    assign bus.IRo       = ir_q;
    assign bus.ALUOut    = alu_q;
    assign bus.Bo        = b_q;
    assign bus.Cond      = cond_q;
    assign bus.Target    = target_q;
endmodule

// File: tb/tb_ex_seg.sv
// Self-checking bench for ex_seg: a transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_ex_seg;
    logic clk = 1'b0;
    logic rst;
    int   nvec  = 0;
    int   nfail = 0;

    ex_seg_if bus ();

    ex_seg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic        cond;
        logic [31:0] tgt;
        logic        mul;
    } res_t;

    // Architectural meaning of one instruction.
    function automatic res_t exec(logic [31:0] npc, logic [31:0] ir, logic [31:0] a,
                                  logic [31:0] b, logic [31:0] imm);
        res_t        r;
        logic [5:0]  opc;
        logic [5:0]  fn;
        r   = '0;
        opc = ir[31:26];
        fn  = ir[5:0];
        if (opc == 6'h00) begin
            if (fn == 6'h20)      r.alu = a + b;
            else if (fn == 6'h22) r.alu = a - b;
            else if (fn == 6'h24) r.alu = a & b;
            else if (fn == 6'h25) r.alu = a | b;
            else if (fn == 6'h2A) r.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            else if (fn == 6'h18) r.mul = 1'b1;
        end else if (opc == 6'h08 || opc == 6'h23 || opc == 6'h2B) begin
            r.alu = a + imm;
        end else if (opc == 6'h0C) begin
            r.alu = a & (ir & 32'h0000FFFF);
        end else if (opc == 6'h04) begin
            r.cond = (a == b);
            r.tgt  = npc + imm * 32'd4;
        end else if (opc == 6'h02) begin
            r.cond = 1'b1;
            r.tgt  = (npc & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 32'd4);
        end
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic        m_valid = 1'b0;
    logic        m_known = 1'b1;
    int          m_busy  = 0;
    logic [31:0] m_npc = '0, m_ir = '0, m_alu = '0, m_bo = '0, m_tgt = '0, m_prod = '0;
    logic        m_cond = 1'b0;
    logic        m_take;
    logic        m_ready;
    res_t        m_res;

    assign m_take  = (m_busy == 0) && (!m_valid || bus.out_ready) && bus.in_valid;
    assign m_ready = !rst && (m_busy == 0) && (!m_valid || bus.out_ready);
    assign m_res   = exec(bus.NPCi, bus.IRi, bus.A, bus.B, bus.Imm);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_known <= 1'b1; m_busy <= 0;
            m_npc <= '0; m_ir <= '0; m_alu <= '0; m_bo <= '0; m_tgt <= '0; m_cond <= 1'b0;
        end else if (m_busy != 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                m_alu   <= m_prod;
                m_valid <= 1'b1;
                m_known <= 1'b1;
            end
        end else if (m_take) begin
            m_npc <= bus.NPCi;
            m_ir  <= bus.IRi;
            m_bo  <= bus.B;
            if (m_res.mul) begin
                m_busy  <= 32;
                m_prod  <= bus.A * bus.B;
                m_valid <= 1'b0;
                m_known <= 1'b0;
                m_cond  <= 1'b0;
                m_tgt   <= '0;
            end else begin
                m_alu   <= m_res.alu;
                m_cond  <= m_res.cond;
                m_tgt   <= m_res.tgt;
                m_valid <= 1'b1;
                m_known <= 1'b1;
            end
        end else if (m_valid && bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {31'h0, bus.in_ready}, {31'h0, m_ready});
        chk("out_valid", {31'h0, bus.out_valid}, {31'h0, m_valid});
        if (m_known) begin
            chk("NPCo", bus.NPCo, m_npc);
            chk("IRo", bus.IRo, m_ir);
            chk("ALUOut", bus.ALUOut, m_alu);
            chk("Bo", bus.Bo, m_bo);
            chk("Cond", {31'h0, bus.Cond}, {31'h0, m_cond});
            chk("Target", bus.Target, m_tgt);
        end
    end

    task automatic drive(logic [31:0] npc, logic [31:0] ir, logic [31:0] a, logic [31:0] b,
                         logic [31:0] imm);
        bus.NPCi = npc; bus.IRi = ir; bus.A = a; bus.B = b; bus.Imm = imm;
        bus.in_valid = 1'b1;
    endtask

    // Present an instruction and return just after the edge that accepted it.
    task automatic send(logic [31:0] npc, logic [31:0] ir, logic [31:0] a, logic [31:0] b,
                        logic [31:0] imm);
        logic took;
        took = 1'b0;
        drive(npc, ir, a, b, imm);
        for (int k = 0; k < 50 && !took; k++) begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!took) chk("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.NPCi = '0; bus.IRi = '0; bus.A = '0; bus.B = '0; bus.Imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        send(32'h4, 32'h0022_1820, 32'd5, 32'd7, 32'h0);
        chk("add_valid", {31'h0, bus.out_valid}, 32'd1);
        chk("add_alu", bus.ALUOut, 32'd12);
        chk("add_cond", {31'h0, bus.Cond}, 32'd0);
        chk("add_ir", bus.IRo, 32'h0022_1820);
        send(32'h8, 32'h2022_FFFB, 32'd3, 32'd0, 32'hFFFF_FFFB);
        chk("addi_alu", bus.ALUOut, 32'hFFFF_FFFE);
        send(32'hC, 32'h0022_182A, 32'hFFFF_FFFF, 32'd1, 32'h0);
        chk("slt_alu", bus.ALUOut, 32'd1);
        send(32'h10, 32'h0022_1822, 32'd10, 32'd3, 32'h0);
        chk("sub_alu", bus.ALUOut, 32'd7);
        send(32'h14, 32'h0022_1824, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0);
        chk("and_alu", bus.ALUOut, 32'h00F0_000F);
        send(32'h18, 32'h0022_1825, 32'hF000_0001, 32'h0000_0010, 32'h0);
        chk("or_alu", bus.ALUOut, 32'hF000_0011);
        send(32'h1C, 32'h3022_F0F0, 32'hFFFF_1234, 32'd0, 32'hFFFF_F0F0);
        chk("andi_alu", bus.ALUOut, 32'h0000_1030);
        send(32'h20, 32'h8C22_0008, 32'h100, 32'd0, 32'h8);
        chk("lw_alu", bus.ALUOut, 32'h108);
        send(32'h24, 32'hAC22_FFFC, 32'h100, 32'h55, 32'hFFFF_FFFC);
        chk("sw_alu", bus.ALUOut, 32'hFC);
        chk("sw_bo", bus.Bo, 32'h55);
        send(32'h100, 32'h1022_0004, 32'd9, 32'd9, 32'd4);
        chk("beq_cond", {31'h0, bus.Cond}, 32'd1);
        chk("beq_tgt", bus.Target, 32'h110);
        chk("beq_alu", bus.ALUOut, 32'd0);
        send(32'h100, 32'h1022_0004, 32'd9, 32'd8, 32'd4);
        chk("beq_nt_cond", {31'h0, bus.Cond}, 32'd0);
        send(32'h1000_0004, 32'h0800_0020, 32'd0, 32'd0, 32'h0);
        chk("j_cond", {31'h0, bus.Cond}, 32'd1);
        chk("j_tgt", bus.Target, 32'h1000_0080);
        send(32'h28, 32'h0, 32'd1, 32'd2, 32'd3);
        chk("nop_valid", {31'h0, bus.out_valid}, 32'd1);
        chk("nop_alu", bus.ALUOut, 32'd0);
        send(32'h2C, 32'hFC00_0000, 32'd1, 32'd2, 32'd3);
        chk("badop_tgt", bus.Target, 32'd0);
        send(32'h30, 32'h0022_183F, 32'd1, 32'd2, 32'd3);
        chk("badfn_alu", bus.ALUOut, 32'd0);

        // Multiply: result exactly 32 edges after acceptance.
        send(32'h40, 32'h0022_1818, 32'h0000_FFFF, 32'h0001_0001, 32'h0);
        chk("mul_acc_valid", {31'h0, bus.out_valid}, 32'd0);
        chk("mul_acc_ready", {31'h0, bus.in_ready}, 32'd0);
        for (int k = 1; k < 32; k++) begin
            @(posedge clk); #1;
            chk("mul_busy_valid", {31'h0, bus.out_valid}, 32'd0);
            chk("mul_busy_ready", {31'h0, bus.in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        chk("mul_done_valid", {31'h0, bus.out_valid}, 32'd1);
        chk("mul_done_alu", bus.ALUOut, 32'hFFFF_FFFF);

        // Backpressure, then consume and accept on the same edge.
        send(32'h50, 32'h0022_1820, 32'd20, 32'd22, 32'h0);
        bus.out_ready = 1'b0;
        drive(32'h54, 32'h0022_1820, 32'd1, 32'd2, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'h0, bus.out_valid}, 32'd1);
            chk("bp_alu", bus.ALUOut, 32'd42);
            chk("bp_ready", {31'h0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("swap_valid", {31'h0, bus.out_valid}, 32'd1);
        chk("swap_alu", bus.ALUOut, 32'd3);
        @(posedge clk); #1;
        chk("drain_valid", {31'h0, bus.out_valid}, 32'd0);
        chk("drain_alu", bus.ALUOut, 32'd3);

        // Consume alongside a multiply accept, then reset ten cycles into it.
        send(32'h60, 32'h0022_1820, 32'd1, 32'd1, 32'h0);
        send(32'h64, 32'h0022_1818, 32'd123, 32'd456, 32'h0);
        chk("mulswap_valid", {31'h0, bus.out_valid}, 32'd0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mrst_valid", {31'h0, bus.out_valid}, 32'd0);
        chk("mrst_alu", bus.ALUOut, 32'd0);
        chk("mrst_ir", bus.IRo, 32'd0);
        chk("mrst_npc", bus.NPCo, 32'd0);
        chk("mrst_bo", bus.Bo, 32'd0);
        chk("mrst_tgt", {bus.Target[31:1], bus.Target[0] | bus.Cond}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        send(32'h70, 32'h0022_1818, 32'd6, 32'd7, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            seen = bus.out_valid;
        end
        chk("mul2_seen", {31'h0, seen}, 32'd1);
        chk("mul2_alu", bus.ALUOut, 32'd42);
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
